// File: rtl/axis_tx_sched_pkg.sv
// Shared state encoding, default sizing and width helpers for the TX frame scheduler.
package axis_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned NUM_SRC_DEF         = 2;
    localparam int unsigned DATA_W_DEF          = 64;
    localparam int unsigned IFG_CYCLES_DEF      = 3;
    localparam int unsigned MAX_FRAME_BEATS_DEF = 1024;
    localparam int unsigned UNDERRUN_CNT_W      = 16;

    // clog2 that never returns zero, so single-entry counters/indices stay 1 bit wide
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_tx_frame_scheduler_if.sv
// Source-FIFO side and GT TX side of the frame scheduler as one bundle.
interface axis_tx_frame_scheduler_if
    import axis_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_SRC_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
);
    logic [NUM_SRC-1:0]        src_min_level;
    logic [NUM_SRC-1:0]        src_tvalid;
    logic [NUM_SRC-1:0]        src_tlast;
    logic [NUM_SRC*DATA_W-1:0] src_tdata;
    logic [NUM_SRC-1:0]        src_rd_en;
    logic                      m_tvalid;
    logic [DATA_W-1:0]         m_tdata;
    logic                      m_tlast;
    logic                      m_tready;

    modport master (
        input  src_min_level, src_tvalid, src_tlast, src_tdata, m_tready,
        output src_rd_en, m_tvalid, m_tdata, m_tlast
    );

    modport slave (
        output src_min_level, src_tvalid, src_tlast, src_tdata, m_tready,
        input  src_rd_en, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester searching cyclically from rr_last+1.
module rr_arbiter
    import axis_tx_sched_pkg::*;
#(
    parameter  int unsigned NUM_SRC = NUM_SRC_DEF,
    localparam int unsigned IDX_W   = width_of(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   rr_last,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // Walk from lowest to highest priority so the nearest requester is written last and wins
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        for (int unsigned off = NUM_SRC; off >= 1; off--) begin
            idx = (32'(rr_last) + off) % NUM_SRC;
            if (req[IDX_W'(idx)]) begin
                grant               = '0;
                grant[IDX_W'(idx)]  = 1'b1;
                grant_idx           = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/axis_tx_frame_scheduler.sv
// Frame-atomic round-robin scheduler from threshold-gated FWFT FIFOs onto the GT TX stream.
module axis_tx_frame_scheduler
    import axis_tx_sched_pkg::*;
#(
    parameter  int unsigned NUM_SRC         = NUM_SRC_DEF,
    parameter  int unsigned DATA_W          = DATA_W_DEF,
    parameter  int unsigned IFG_CYCLES      = IFG_CYCLES_DEF,
    parameter  int unsigned MAX_FRAME_BEATS = MAX_FRAME_BEATS_DEF,
    localparam int unsigned IDX_W           = width_of(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      gt_tx_active,
    axis_tx_frame_scheduler_if.master bus,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      underrun_pulse,
    output logic                      oversize_pulse,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

    localparam int unsigned BEAT_W = width_of(MAX_FRAME_BEATS);
    localparam int unsigned GAP_W  = width_of(IFG_CYCLES + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_FRAME_BEATS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1);

    state_t                    state, state_d;
    logic [IDX_W-1:0]          rr_last, rr_last_d, grant_d, arb_idx;
    logic [NUM_SRC-1:0]        eligible, arb_grant, rd_en;
    logic [BEAT_W-1:0]         beat_cnt, beat_d;
    logic [GAP_W-1:0]          gap_cnt, gap_d;
    logic [UNDERRUN_CNT_W-1:0] ucnt_d;
    logic                      prev_valid;
    logic                      cur_valid, cur_last, m_valid, m_last;
    logic [DATA_W-1:0]         cur_data, m_data;

    assign eligible = bus.src_min_level & bus.src_tvalid;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .req       (eligible),
        .rr_last   (rr_last),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        cur_valid = bus.src_tvalid[grant_idx];
        cur_last  = bus.src_tlast[grant_idx];
        cur_data  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (IDX_W'(i) == grant_idx) cur_data = bus.src_tdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d        = state;
        grant_d        = grant_idx;
        rr_last_d      = rr_last;
        beat_d         = beat_cnt;
        gap_d          = gap_cnt;
        ucnt_d         = underrun_cnt;
        rd_en          = '0;
        m_valid        = 1'b0;
        m_data         = '0;
        m_last         = 1'b0;
        frame_done     = 1'b0;
        underrun_pulse = 1'b0;
        oversize_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (gt_tx_active && (|arb_grant)) begin
                    grant_d   = arb_idx;
                    rr_last_d = arb_idx;
                    state_d   = XFER;
                end
            end
            XFER: begin
                m_valid          = cur_valid;
                m_data           = cur_data;
                m_last           = cur_last | (beat_cnt == BEAT_LAST);
                rd_en[grant_idx] = bus.m_tready & cur_valid;
                // A FWFT source dropping TVALID mid-frame starves the GT; flag it but keep the grant
                if (prev_valid && !cur_valid) begin
                    underrun_pulse = 1'b1;
                    if (underrun_cnt != '1) ucnt_d = underrun_cnt + UNDERRUN_CNT_W'(1);
                end
                if (cur_valid && bus.m_tready) begin
                    if (m_last) begin
                        frame_done     = 1'b1;
                        oversize_pulse = ~cur_last;
                        beat_d         = '0;
                        gap_d          = '0;
                        state_d        = (IFG_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        beat_d = beat_cnt + BEAT_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_d = IDLE;
                else                     gap_d   = gap_cnt + GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant_idx    <= '0;
            rr_last      <= IDX_W'(NUM_SRC - 1);
            beat_cnt     <= '0;
            gap_cnt      <= '0;
            prev_valid   <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            state        <= state_d;
            grant_idx    <= grant_d;
            rr_last      <= rr_last_d;
            beat_cnt     <= beat_d;
            gap_cnt      <= gap_d;
            prev_valid   <= m_valid;
            underrun_cnt <= ucnt_d;
        end
    end

    assign busy          = (state != IDLE);
    assign bus.src_rd_en = rd_en;
    assign bus.m_tvalid  = m_valid;
    assign bus.m_tdata   = m_data;
    assign bus.m_tlast   = m_last;

endmodule

// File: tb/tb_axis_tx_frame_scheduler.sv
// Bench for axis_tx_frame_scheduler: FWFT source model, per-source scoreboard, vector table and corner sequences.
`timescale 1ns/1ps
module tb_axis_tx_frame_scheduler;
    import axis_tx_sched_pkg::*;

    localparam int unsigned NS   = 2;
    localparam int unsigned DW   = 64;
    localparam int unsigned IFG  = 3;
    localparam int unsigned MAXB = 8;

    typedef logic [64:0] word_t;
    typedef struct {
        int src;
        int len;
        int frames;
        int ovs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic gt_tx_active;
    logic [width_of(NS)-1:0]   grant_idx;
    logic                      busy, frame_done, underrun_pulse, oversize_pulse;
    logic [UNDERRUN_CNT_W-1:0] underrun_cnt;

    axis_tx_frame_scheduler_if #(.NUM_SRC(NS), .DATA_W(DW)) bus();

    axis_tx_frame_scheduler #(
        .NUM_SRC(NS), .DATA_W(DW), .IFG_CYCLES(IFG), .MAX_FRAME_BEATS(MAXB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .gt_tx_active   (gt_tx_active),
        .bus            (bus),
        .grant_idx      (grant_idx),
        .busy           (busy),
        .frame_done     (frame_done),
        .underrun_pulse (underrun_pulse),
        .oversize_pulse (oversize_pulse),
        .underrun_cnt   (underrun_cnt)
    );

    always #5 clk = ~clk;

    word_t       src_q [NS][$];
    word_t       exp_q [NS][$];
    int unsigned done_grants[$];
    logic [NS-1:0] pause, lvl_en;
    int checks, failures;
    int rd_total[NS];
    int und_seen, ovs_seen, frames_seen;
    int frame_id;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Scoreboard push happens together with loading the source FIFO model
    task automatic load_frame(input int src, input int len);
        word_t w;
        for (int b = 0; b < len; b++) begin
            w = {1'(b == len - 1), 8'(src), 24'(frame_id), 32'($urandom)};
            src_q[src].push_back(w);
            exp_q[src].push_back(w);
        end
        frame_id++;
        lvl_en[src] = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while ((src_q[0].size() != 0 || src_q[1].size() != 0 || busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, " completes"}, 64'(n < max), 64'd1);
    endtask

    // FWFT FIFO model: pops on a sampled read strobe, presents the head word
    initial begin : drv
        logic [NS-1:0]    rd_s, v, lv, tl;
        logic [NS*DW-1:0] d;
        bus.src_tvalid    = '0;
        bus.src_tlast     = '0;
        bus.src_tdata     = '0;
        bus.src_min_level = '0;
        forever begin
            @(negedge clk);
            rd_s = bus.src_rd_en;
            @(posedge clk);
            #2;
            v = '0; lv = '0; tl = '0; d = '0;
            for (int i = 0; i < NS; i++) begin
                if (rst_n && rd_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    v[i]  = ~pause[i];
                    lv[i] = lvl_en[i];
                    tl[i] = src_q[i][0][64];
                    d[i*DW +: DW] = src_q[i][0][63:0];
                end
            end
            bus.src_tvalid    = v;
            bus.src_tlast     = tl;
            bus.src_tdata     = d;
            bus.src_min_level = lv;
        end
    end

    // Output monitor: compares every presented beat against the granted source's expected queue
    initial begin : mon
        word_t       w;
        logic        el;
        int unsigned g;
        int          mon_beat;
        mon_beat = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_beat = 0;
            end else begin
                for (int i = 0; i < NS; i++) rd_total[i] += int'(bus.src_rd_en[i]);
                und_seen += int'(underrun_pulse);
                ovs_seen += int'(oversize_pulse);
                g = 32'(grant_idx);
                if (bus.m_tvalid) begin
                    check("beat expected", 64'(exp_q[g].size() != 0), 64'd1);
                    if (exp_q[g].size() != 0) begin
                        w  = exp_q[g][0];
                        el = w[64] || (mon_beat == int'(MAXB) - 1);
                        check("m_tdata", bus.m_tdata, w[63:0]);
                        check("m_tlast", 64'(bus.m_tlast), 64'(el));
                        if (bus.m_tready) begin
                            void'(exp_q[g].pop_front());
                            check("src_rd_en beat", 64'(bus.src_rd_en), 64'(NS'(1) << g));
                            check("frame_done", 64'(frame_done), 64'(el));
                            check("oversize_pulse", 64'(oversize_pulse), 64'(el & ~w[64]));
                            if (el) begin
                                mon_beat = 0;
                                done_grants.push_back(g);
                                frames_seen++;
                            end else begin
                                mon_beat++;
                            end
                        end else begin
                            check("src_rd_en stall", 64'(bus.src_rd_en), 64'd0);
                        end
                    end
                end else begin
                    check("src_rd_en idle", 64'(bus.src_rd_en), 64'd0);
                    check("frame_done idle", 64'(frame_done), 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[6];
        logic [8:0] tr_v, tr_b;
        logic [3:0] gv;
        int f0, o0, r0, u0, n, c;

        vecs[0] = '{src: 0, len: 4,  frames: 1, ovs: 0};
        vecs[1] = '{src: 1, len: 3,  frames: 1, ovs: 0};
        vecs[2] = '{src: 0, len: 1,  frames: 1, ovs: 0};
        vecs[3] = '{src: 1, len: 8,  frames: 1, ovs: 0};
        vecs[4] = '{src: 0, len: 10, frames: 2, ovs: 1};
        vecs[5] = '{src: 1, len: 9,  frames: 2, ovs: 1};

        checks = 0; failures = 0; frame_id = 0;
        und_seen = 0; ovs_seen = 0; frames_seen = 0;
        for (int i = 0; i < NS; i++) rd_total[i] = 0;
        pause = '0; lvl_en = '0;
        rst_n = 1'b0; gt_tx_active = 1'b1; bus.m_tready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst m_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst grant_idx", 64'(grant_idx), 64'd0);
        check("rst underrun_cnt", 64'(underrun_cnt), 64'd0);
        check("rst src_rd_en", 64'(bus.src_rd_en), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single 4-beat frame: 1-cycle grant latency, 4 valid beats, 3 gap cycles
        @(posedge clk); #1 load_frame(0, 4);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tr_v[i] = bus.m_tvalid;
            tr_b[i] = busy;
        end
        check("t1 m_tvalid trace", 64'(tr_v), 64'(9'b000011110));
        check("t1 busy trace", 64'(tr_b), 64'(9'b011111110));
        wait_idle("t1", 100);

        // Both sources backlogged: grants alternate starting after src0
        done_grants.delete();
        @(posedge clk); #1;
        load_frame(0, 2); load_frame(0, 2); load_frame(1, 2); load_frame(1, 2);
        wait_idle("alt", 200);
        check("alt frames", 64'(done_grants.size()), 64'd4);
        gv = '0;
        for (int i = 0; i < 4 && i < done_grants.size(); i++) gv[i] = done_grants[i][0];
        check("alt grant order", 64'(gv), 64'(4'b0101));

        for (int v = 0; v < 6; v++) begin
            f0 = frames_seen; o0 = ovs_seen; r0 = rd_total[vecs[v].src];
            @(posedge clk); #1 load_frame(vecs[v].src, vecs[v].len);
            wait_idle($sformatf("vec%0d", v), 200);
            check($sformatf("vec%0d frames", v), 64'(frames_seen - f0), 64'(vecs[v].frames));
            check($sformatf("vec%0d oversize", v), 64'(ovs_seen - o0), 64'(vecs[v].ovs));
            check($sformatf("vec%0d rd strobes", v), 64'(rd_total[vecs[v].src] - r0), 64'(vecs[v].len));
        end

        // Source drops TVALID for 2 cycles after beat 2 of 5
        u0 = und_seen; f0 = frames_seen; r0 = rd_total[0];
        @(posedge clk); #1 load_frame(0, 5);
        c = 0; n = 0;
        while (c < 2 && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.src_rd_en[0]) c++;
        end
        check("und reach beat2", 64'(c), 64'd2);
        @(posedge clk); #1 pause[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 pause[0] = 1'b0;
        wait_idle("und", 100);
        check("und pulses", 64'(und_seen - u0), 64'd1);
        check("und count", 64'(underrun_cnt), 64'd1);
        check("und frames", 64'(frames_seen - f0), 64'd1);
        check("und rd strobes", 64'(rd_total[0] - r0), 64'd5);

        // GT inactive blocks grants; first read 2 cycles after it rises
        r0 = rd_total[0];
        @(posedge clk); #1 gt_tx_active = 1'b0; load_frame(0, 4);
        repeat (20) @(negedge clk);
        check("gt blocked rd", 64'(rd_total[0] - r0), 64'd0);
        check("gt blocked busy", 64'(busy), 64'd0);
        @(posedge clk); #1 gt_tx_active = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.src_rd_en[0] && n < 20);
        check("gt grant latency", 64'(n), 64'd2);
        wait_idle("gt", 100);

        // Backpressure toggling every cycle on a 6-beat frame
        r0 = rd_total[1]; f0 = frames_seen;
        @(posedge clk); #1 load_frame(1, 6);
        n = 0;
        while ((src_q[1].size() != 0 || busy) && n < 100) begin
            @(posedge clk);
            #1 bus.m_tready = ~bus.m_tready;
            n++;
        end
        bus.m_tready = 1'b1;
        check("tready completes", 64'(n < 100), 64'd1);
        check("tready rd strobes", 64'(rd_total[1] - r0), 64'd6);
        check("tready frames", 64'(frames_seen - f0), 64'd1);

        // Reset mid-frame on src0, then src0 must win over src1 after release
        @(posedge clk); #1 load_frame(0, 6);
        c = 0; n = 0;
        while (c < 2 && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.src_rd_en[0]) c++;
        end
        #1 rst_n = 1'b0;
        #1;
        check("midrst m_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("midrst m_tlast", 64'(bus.m_tlast), 64'd0);
        check("midrst m_tdata", bus.m_tdata, 64'd0);
        check("midrst src_rd_en", 64'(bus.src_rd_en), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst underrun_cnt", 64'(underrun_cnt), 64'd0);
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        done_grants.delete();
        load_frame(0, 2);
        load_frame(1, 2);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle("postrst", 100);
        check("postrst frames", 64'(done_grants.size()), 64'd2);
        gv = '0;
        for (int i = 0; i < 2 && i < done_grants.size(); i++) gv[i] = done_grants[i][0];
        check("postrst grant order", 64'(gv), 64'(4'b0010));

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
